// File: rtl/fifo_pkg.sv
// Shared types for the single-clock queues used in the front-end and issue paths.
package fifo_pkg;

    typedef enum logic {
        FIFO_FWFT,
        FIFO_REG_READ
    } fifo_mode_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer: the low bits index storage and the MSB toggles on every lap.
module fifo_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + W'(1);
    end

endmodule

// File: rtl/fifo_q.sv
// Parametrised synchronous FIFO with valid/ready on both sides, one-cycle flush,
// occupancy count, almost-full flag and selectable FWFT / registered read.
module fifo_q
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH   = 64,
    parameter int         DEPTH        = 16,
    parameter fifo_mode_t READ_MODE    = FIFO_FWFT,
    parameter int         AFULL_THRESH = DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [DATA_WIDTH-1:0]     enq_data,
    output logic                      deq_valid,
    input  logic                      deq_ready,
    output logic [DATA_WIDTH-1:0]     deq_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_q: DEPTH must be a power of two >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("fifo_q: AFULL_THRESH must be in 1..DEPTH");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("fifo_q: DATA_WIDTH must be >= 1");
    end

    logic [PW-1:0] wptr, rptr, cnt_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic empty, full, enq_fire, deq_fire;

    // Full when the pointers sit on the same slot but on different laps.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign enq_ready   = ~full;
    assign deq_valid   = ~empty;
    assign count       = cnt_q;
    assign almost_full = (cnt_q >= AFULL_T);

    assign enq_fire = enq_valid && !full;
    assign deq_fire = deq_ready && !empty;

    fifo_ptr #(.W(PW)) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (enq_fire),
        .ptr (wptr)
    );

    fifo_ptr #(.W(PW)) u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (deq_fire),
        .ptr (rptr)
    );

    // Storage is never cleared; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (!rst && !flush && enq_fire)
            mem[wptr[AW-1:0]] <= enq_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush)
            cnt_q <= '0;
        else begin
            case ({enq_fire, deq_fire})
                2'b10:   cnt_q <= cnt_q + PW'(1);
                2'b01:   cnt_q <= cnt_q - PW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    if (READ_MODE == FIFO_FWFT) begin : g_fwft
        assign deq_data = mem[rptr[AW-1:0]];
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] rd_q;

        // Flush keeps the last popped word visible; only reset clears it.
        always_ff @(posedge clk) begin
            if (rst)
                rd_q <= '0;
            else if (!flush && deq_fire)
                rd_q <= mem[rptr[AW-1:0]];
        end

        assign deq_data = rd_q;
    end

endmodule
